// File: rtl/ysyx_24110015_axil_sram.sv
// AXI4-Lite responder over a word-addressed SRAM, one transaction in flight.
// Response latency is LAT extra cycles after the address handshake.
// Optional macro RAND_DELAY_EN: adds LFSR-driven random latency (+0..3)
// and random ready stalls in IDLE.
module ysyx_24110015_axil_sram #(
  parameter int                 ADDR_W    = 32,
  parameter int                 DEPTH_LG2 = 16,
  parameter logic [ADDR_W-1:0]  BASE      = 32'h8000_0000,
  parameter int                 LAT       = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready
);

  localparam int CW = 5;  // holds LAT(15) + random extra(3)

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP} state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_ld;
  logic [DEPTH_LG2-1:0]   req_idx;
  logic                   req_map;
  logic [31:0]            wr_data, rdata_q;
  logic [3:0]             wr_strb;
  logic [31:0]            mem [0:(1<<DEPTH_LG2)-1];
  logic [ADDR_W-1:0]      rd_off, wr_off;
  logic                   rd_map, wr_map;
  logic                   rd_hs, wr_hs, idle_rdy, cnt_done;

  // Offset from BASE; addresses below BASE wrap to huge offsets and fall out of range.
  assign rd_off   = araddr - BASE;
  assign wr_off   = awaddr - BASE;
  assign rd_map   = (rd_off >> (DEPTH_LG2 + 2)) == '0;
  assign wr_map   = (wr_off >> (DEPTH_LG2 + 2)) == '0;
  assign cnt_done = (cnt == '0);
  assign rd_hs    = arvalid & arready;
  assign wr_hs    = awready;  // awready already implies awvalid & wvalid
  assign rdata    = rdata_q;

`ifdef RAND_DELAY_EN
  logic [7:0] lfsr;

  // Free-running LFSR x^8+x^6+x^5+x^4+1, reseeded on reset.
  always_ff @(posedge clk) begin
    if (!rst) lfsr <= 8'h5A;
    else      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign idle_rdy = lfsr[2];
  assign cnt_ld   = CW'(LAT) + CW'(lfsr[1:0]);
`else
  assign idle_rdy = 1'b1;
  assign cnt_ld   = CW'(LAT);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state: read takes priority over a simultaneous write.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rd_hs) state_nxt = RD_WAIT;
               else if (wr_hs) state_nxt = WR_WAIT;
      RD_WAIT: if (cnt_done) state_nxt = RD_RESP;
      RD_RESP: if (rready) state_nxt = IDLE;
      WR_WAIT: if (cnt_done) state_nxt = WR_RESP;
      WR_RESP: if (bready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs; gated by rst so nothing is offered while reset is held.
  always_comb begin
    arready = 1'b0;
    awready = 1'b0;
    wready  = 1'b0;
    rvalid  = 1'b0;
    bvalid  = 1'b0;
    rresp   = 2'b00;
    bresp   = 2'b00;
    case (state)
      IDLE: if (rst && idle_rdy) begin
        arready = 1'b1;
        awready = awvalid & wvalid & ~arvalid;
        wready  = awvalid & wvalid & ~arvalid;
      end
      RD_RESP: begin
        rvalid = 1'b1;
        rresp  = req_map ? 2'b00 : 2'b11;
      end
      WR_RESP: begin
        bvalid = 1'b1;
        bresp  = req_map ? 2'b00 : 2'b11;
      end
      default: ;
    endcase
  end

  // Latency counter and read-data register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt     <= '0;
      rdata_q <= '0;
    end else begin
      if (rd_hs || wr_hs)
        cnt <= cnt_ld;
      else if ((state == RD_WAIT || state == WR_WAIT) && !cnt_done)
        cnt <= cnt - 1'b1;
      if (state == RD_WAIT && cnt_done)
        rdata_q <= req_map ? mem[req_idx] : 32'h0;
    end
  end

  // Request capture; contents only matter once a handshake has loaded them.
  always_ff @(posedge clk) begin
    if (rd_hs) begin
      req_idx <= rd_off[DEPTH_LG2+1:2];
      req_map <= rd_map;
    end else if (wr_hs) begin
      req_idx <= wr_off[DEPTH_LG2+1:2];
      req_map <= wr_map;
      wr_data <= wdata;
      wr_strb <= wstrb;
    end
  end

  // Memory write commits on the WR_WAIT->WR_RESP edge; a reset before then drops it.
  always_ff @(posedge clk) begin
    if (rst && state == WR_WAIT && cnt_done && req_map)
      for (int b = 0; b < 4; b++)
        if (wr_strb[b]) mem[req_idx][8*b +: 8] <= wr_data[8*b +: 8];
  end

endmodule

// File: tb/tb_ysyx_24110015_axil_sram.sv
// Randomized self-checking bench for ysyx_24110015_axil_sram against a word-map model.
module tb_ysyx_24110015_axil_sram;
  localparam int          LAT  = 2;
  localparam int          DLG  = 16;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0, rst = 1'b0;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0, rdata;
  logic        arvalid = 1'b0, arready, rvalid, rready = 1'b1;
  logic        awvalid = 1'b0, awready, wvalid = 1'b0, wready;
  logic        bvalid, bready = 1'b1;
  logic [3:0]  wstrb = '0;
  logic [1:0]  rresp, bresp;

  int total = 0, bad = 0;
  logic [31:0] ref_mem [int];

  always #5 clk = ~clk;

  ysyx_24110015_axil_sram #(.ADDR_W(32), .DEPTH_LG2(DLG), .BASE(BASE), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit mapped(input logic [31:0] a);
    longint x = a;
    return x >= longint'(BASE) && x < longint'(BASE) + 4 * (longint'(1) << DLG);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (!mapped(a)) return 32'h0;
    return ref_mem.exists(widx(a)) ? ref_mem[widx(a)] : 32'hx;
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    if (!mapped(a)) return;
    w = ref_mem.exists(widx(a)) ? ref_mem[widx(a)] : 32'h0;
    for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    ref_mem[widx(a)] = w;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic chk_lat(input string tag, input int lat);
`ifdef RAND_DELAY_EN
    chk(tag, 32'(lat >= LAT + 1 && lat <= LAT + 4), 32'd1);
`else
    chk(tag, 32'(lat), 32'(LAT + 1));
`endif
  endtask

  // Present AR and leave after the handshake edge.
  task automatic start_rd(input logic [31:0] a);
    int n = 0;
    araddr = a; arvalid = 1'b1; #1;
    while (!arready && n < 50) begin tick(); #1; n++; end
    if (!arready) chk("ar_timeout", 32'd0, 32'd1);
    tick();
    arvalid = 1'b0;
  endtask

  task automatic fin_rd(input logic [31:0] a, output logic [31:0] d);
    int lat = 0;
    while (!rvalid && lat < 50) begin tick(); lat++; end
    chk_lat("rd_lat", lat);
    d = rdata;
    chk("rdata", rdata, ref_read(a));
    chk("rresp", 32'(rresp), mapped(a) ? 32'd0 : 32'd3);
    tick();
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d);
    start_rd(a);
    fin_rd(a, d);
  endtask

  task automatic start_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; #1;
    while (!(awready && wready) && n < 50) begin tick(); #1; n++; end
    if (!(awready && wready)) chk("aw_timeout", 32'd0, 32'd1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic fin_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int lat = 0;
    while (!bvalid && lat < 50) begin tick(); lat++; end
    chk_lat("wr_lat", lat);
    chk("bresp", 32'(bresp), mapped(a) ? 32'd0 : 32'd3);
    tick();
    ref_write(a, d, s);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    start_wr(a, d, s);
    fin_wr(a, d, s);
  endtask

  initial begin
    logic [31:0] d, held, a, pool [8];
    int n;
    pool = '{32'h8000_0000, 32'h8000_0010, 32'h8000_0020, 32'h8003_FFFC,
             32'h8001_2344, 32'h8000_0100, 32'h8002_0000, 32'h8000_0004};

    // Reset values
    tick(); tick();
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_rvalid",  32'(rvalid),  32'd0);
    chk("rst_bvalid",  32'(bvalid),  32'd0);
    chk("rst_rdata",   rdata,        32'd0);
    chk("rst_resp",    32'({rresp, bresp}), 32'd0);
    rst = 1'b1; #1;
`ifndef RAND_DELAY_EN
    chk("rel_arready", 32'(arready), 32'd1);
`endif

    // Full write then read-back, partial strobe merge
    do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
    do_read(32'h8000_0010, d);
    chk("rd_full", d, 32'hDEAD_BEEF);
    do_write(32'h8000_0010, 32'h0000_AA00, 4'b0010);
    do_read(32'h8000_0013, d);
    chk("rd_strb", d, 32'hDEAD_AAEF);
    do_write(32'h8000_0010, 32'hFFFF_FFFF, 4'b0000);
    do_read(32'h8000_0010, d);
    chk("rd_strb0", d, 32'hDEAD_AAEF);

    // Unmapped accesses on both sides of the window
    do_write(32'h8000_0000, 32'h1234_5678, 4'hF);
    do_read(32'h7FFF_FFFC, d);
    do_read(32'h8004_0000, d);
    do_write(32'h8004_0000, 32'hCAFE_F00D, 4'hF);
    do_write(32'h7FFF_FFFC, 32'hCAFE_F00D, 4'hF);
    do_write(32'h8003_FFFC, 32'hA5A5_5A5A, 4'hF);
    do_read(32'h8003_FFFC, d);
    do_read(32'h8000_0000, d);
    chk("no_alias", d, 32'h1234_5678);

    // Simultaneous AR and AW+W: read first, R held 5 cycles
    araddr = 32'h8000_0010; arvalid = 1'b1;
    awaddr = 32'h8000_0020; wdata = 32'h0BAD_F00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    rready = 1'b0; #1;
    chk("both_awready", 32'(awready | wready), 32'd0);
    n = 0;
    while (!arready && n < 50) begin tick(); #1; n++; end
    tick();
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin tick(); n++; end
    chk("hold_rvalid0", 32'(rvalid), 32'd1);
    held = rdata;
    chk("hold_rdata0", held, 32'hDEAD_AAEF);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_rvalid", 32'(rvalid), 32'd1);
      chk("hold_rdata", rdata, held);
      chk("hold_awready", 32'(awready), 32'd0);
    end
    rready = 1'b1;
    tick();
    chk("post_r_rvalid", 32'(rvalid), 32'd0);
    n = 0;
    while (!awready && n < 50) begin tick(); #1; n++; end
    chk("post_r_awready", 32'(awready), 32'd1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    fin_wr(32'h8000_0020, 32'h0BAD_F00D, 4'hF);
    do_read(32'h8000_0020, d);

    // Reset mid-read
    start_rd(32'h8000_0010);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_rvalid", 32'(rvalid), 32'd0);
      chk("mid_arready", 32'(arready), 32'd0);
      chk("mid_rdata", rdata, 32'd0);
    end
    rst = 1'b1; #1;
`ifndef RAND_DELAY_EN
    chk("mid_rel_arready", 32'(arready), 32'd1);
`endif

    // Reset mid-write: uncommitted write must vanish
    start_wr(32'h8000_0010, 32'h5555_5555, 4'hF);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midw_bvalid", 32'(bvalid), 32'd0);
    end
    rst = 1'b1;
    do_read(32'h8000_0010, d);
    chk("midw_keep", d, 32'hDEAD_AAEF);

    // Randomized mix over a word pool plus unmapped reads
    for (int i = 0; i < 8; i++) do_write(pool[i], $urandom, 4'hF);
    for (int i = 0; i < 100; i++) begin
      a = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0, 1, 2: do_write(a, $urandom, 4'($urandom_range(0, 15)));
        3: begin
          a = $urandom;
          if (mapped(a)) a = 32'h0000_1000;
          do_read(a, d);
        end
        default: do_read(a, d);
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=%0d exp=0", 1);
    $fatal(1, "timeout");
  end
endmodule
